alu_exec_unit: RTL and testbench

//  Integer execute stage sitting between the reservation station and the ALU common data bus (CDB).

---
 rtl/alu_exec_unit_pkg.sv | 50 +++++
 rtl/alu_exec_unit_compute.sv | 74 +++++++
 rtl/alu_exec_unit.sv | 117 +++++++++++
 tb/tb_alu_exec_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, internal opcode encodings and tag constants for the ALU execute stage.
package alu_exec_unit_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int ROB_TAG_WIDTH       = 4;
  localparam int INSIDE_OPCODE_WIDTH = 6;

  // Tag value that marks the CDB as idle; never a real ROB entry.
  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

  // Internal opcodes as produced by the decoder / reservation station.
  typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_SLTIU = 6'd13,
    OP_XORI  = 6'd14,
    OP_ORI   = 6'd15,
    OP_ANDI  = 6'd16,
    OP_SLLI  = 6'd17,
    OP_SRLI  = 6'd18,
    OP_SRAI  = 6'd19,
    OP_ADD   = 6'd20,
    OP_SUB   = 6'd21,
    OP_SLL   = 6'd22,
    OP_SLT   = 6'd23,
    OP_SLTU  = 6'd24,
    OP_XOR   = 6'd25,
    OP_SRL   = 6'd26,
    OP_SRA   = 6'd27,
    OP_OR    = 6'd28,
    OP_AND   = 6'd29
  } op_e;

  // True for every opcode that produces a result; NOP and unassigned codes are not issued.
  function automatic logic op_known(input logic [INSIDE_OPCODE_WIDTH-1:0] op);
    return (op != OP_NOP) && (op <= OP_AND);
  endfunction

endpackage

// File: rtl/alu_exec_unit_compute.sv
// Purely combinational integer datapath: {op, v1, v2, imm, pc} -> {value, target, jump_flag}.
module alu_compute
  import alu_exec_unit_pkg::*;
(
  input  logic [INSIDE_OPCODE_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]          v1,
  input  logic [DATA_WIDTH-1:0]          v2,
  input  logic [DATA_WIDTH-1:0]          imm,
  input  logic [DATA_WIDTH-1:0]          pc,
  output logic [DATA_WIDTH-1:0]          value,
  output logic [DATA_WIDTH-1:0]          target,
  output logic                           jump_flag
);

  logic [4:0]            shamt_reg_op;
  logic [4:0]            shamt_imm_op;
  logic [DATA_WIDTH-1:0] jalr_sum;

  assign shamt_reg_op = v2[4:0];
  assign shamt_imm_op = imm[4:0];
  assign jalr_sum     = v1 + imm;

  // Result selection by opcode; unknown opcodes yield all-zero outputs.
  always_comb begin
    value     = '0;
    target    = '0;
    jump_flag = 1'b0;
    case (op)
      OP_LUI:   value = imm;
      OP_AUIPC: value = pc + imm;
      OP_JAL: begin
        value     = pc + 32'd4;
        target    = pc + imm;
        jump_flag = 1'b1;
      end
      OP_JALR: begin
        value     = pc + 32'd4;
        target    = jalr_sum & ~32'd1;
        jump_flag = 1'b1;
      end
      OP_BEQ:  begin target = pc + imm; jump_flag = (v1 == v2); end
      OP_BNE:  begin target = pc + imm; jump_flag = (v1 != v2); end
      OP_BLT:  begin target = pc + imm; jump_flag = ($signed(v1) <  $signed(v2)); end
      OP_BGE:  begin target = pc + imm; jump_flag = ($signed(v1) >= $signed(v2)); end
      OP_BLTU: begin target = pc + imm; jump_flag = (v1 <  v2); end
      OP_BGEU: begin target = pc + imm; jump_flag = (v1 >= v2); end
      OP_ADDI:  value = v1 + imm;
      OP_SLTI:  value = {31'd0, $signed(v1) < $signed(imm)};
      OP_SLTIU: value = {31'd0, v1 < imm};
      OP_XORI:  value = v1 ^ imm;
      OP_ORI:   value = v1 | imm;
      OP_ANDI:  value = v1 & imm;
      OP_SLLI:  value = v1 << shamt_imm_op;
      OP_SRLI:  value = v1 >> shamt_imm_op;
      OP_SRAI:  value = $unsigned($signed(v1) >>> shamt_imm_op);
      OP_ADD:   value = v1 + v2;
      OP_SUB:   value = v1 - v2;
      OP_SLL:   value = v1 << shamt_reg_op;
      OP_SLT:   value = {31'd0, $signed(v1) < $signed(v2)};
      OP_SLTU:  value = {31'd0, v1 < v2};
      OP_XOR:   value = v1 ^ v2;
      OP_SRL:   value = v1 >> shamt_reg_op;
      OP_SRA:   value = $unsigned($signed(v1) >>> shamt_reg_op);
      OP_OR:    value = v1 | v2;
      OP_AND:   value = v1 & v2;
      default: begin
        value     = '0;
        target    = '0;
        jump_flag = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: takes one RS entry per cycle, computes it, and broadcasts the
// result on the ALU CDB one edge later. A one-entry hold buffer keeps results that
// arrive while the pipeline is frozen (rdy low) so none are lost.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           in_rob_clear,
  input  logic [INSIDE_OPCODE_WIDTH-1:0] in_rs_op,
  input  logic [DATA_WIDTH-1:0]          in_rs_value1,
  input  logic [DATA_WIDTH-1:0]          in_rs_value2,
  input  logic [DATA_WIDTH-1:0]          in_rs_imm,
  input  logic [ROB_TAG_WIDTH-1:0]       in_rs_rob_tag,
  input  logic [DATA_WIDTH-1:0]          in_rs_pc,
  output logic [ROB_TAG_WIDTH-1:0]       out_cdb_tag,
  output logic [DATA_WIDTH-1:0]          out_cdb_value,
  output logic                           out_cdb_jump_flag,
  output logic [DATA_WIDTH-1:0]          out_cdb_target
);

  // Hold buffer: valid bit is reset, payload is plain data.
  logic                           hold_valid;
  logic [INSIDE_OPCODE_WIDTH-1:0] hold_op;
  logic [DATA_WIDTH-1:0]          hold_v1;
  logic [DATA_WIDTH-1:0]          hold_v2;
  logic [DATA_WIDTH-1:0]          hold_imm;
  logic [ROB_TAG_WIDTH-1:0]       hold_tag;
  logic [DATA_WIDTH-1:0]          hold_pc;

  logic                           issue;
  logic                           bcast;
  logic                           hold_load;
  logic                           hold_valid_next;

  logic [INSIDE_OPCODE_WIDTH-1:0] sel_op;
  logic [DATA_WIDTH-1:0]          sel_v1;
  logic [DATA_WIDTH-1:0]          sel_v2;
  logic [DATA_WIDTH-1:0]          sel_imm;
  logic [ROB_TAG_WIDTH-1:0]       sel_tag;
  logic [DATA_WIDTH-1:0]          sel_pc;

  logic [DATA_WIDTH-1:0]          res_value;
  logic [DATA_WIDTH-1:0]          res_target;
  logic                           res_jump;

  // An input counts only if it is a real opcode carrying a real ROB tag.
  assign issue = op_known(in_rs_op) && (in_rs_rob_tag != ZERO_TAG_ROB);

  // The hold entry is older than the input, so it always wins the single ALU.
  assign sel_op  = hold_valid ? hold_op  : in_rs_op;
  assign sel_v1  = hold_valid ? hold_v1  : in_rs_value1;
  assign sel_v2  = hold_valid ? hold_v2  : in_rs_value2;
  assign sel_imm = hold_valid ? hold_imm : in_rs_imm;
  assign sel_tag = hold_valid ? hold_tag : in_rs_rob_tag;
  assign sel_pc  = hold_valid ? hold_pc  : in_rs_pc;

  alu_compute u_compute (
    .op        (sel_op),
    .v1        (sel_v1),
    .v2        (sel_v2),
    .imm       (sel_imm),
    .pc        (sel_pc),
    .value     (res_value),
    .target    (res_target),
    .jump_flag (res_jump)
  );

  // Edge sequencing: flush beats freeze; when frozen the input parks in the hold buffer,
  // when running the hold entry drains first and a concurrent input takes its place.
  always_comb begin
    bcast           = 1'b0;
    hold_load       = 1'b0;
    hold_valid_next = hold_valid;
    if (in_rob_clear) begin
      hold_valid_next = 1'b0;
    end else if (!rdy) begin
      hold_load       = issue;
      hold_valid_next = hold_valid | issue;
    end else begin
      bcast           = hold_valid | issue;
      hold_load       = hold_valid & issue;
      hold_valid_next = hold_valid & issue;
    end
  end

  // CDB output registers and hold-valid flag; idle bus drives zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cdb_tag       <= ZERO_TAG_ROB;
      out_cdb_value     <= '0;
      out_cdb_target    <= '0;
      out_cdb_jump_flag <= 1'b0;
      hold_valid        <= 1'b0;
    end else begin
      hold_valid        <= hold_valid_next;
      out_cdb_tag       <= bcast ? sel_tag    : ZERO_TAG_ROB;
      out_cdb_value     <= bcast ? res_value  : '0;
      out_cdb_target    <= bcast ? res_target : '0;
      out_cdb_jump_flag <= bcast & res_jump;
    end
  end

  // Hold buffer payload capture; meaningful only while hold_valid is set.
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_op  <= in_rs_op;
      hold_v1  <= in_rs_value1;
      hold_v2  <= in_rs_value2;
      hold_imm <= in_rs_imm;
      hold_tag <= in_rs_rob_tag;
      hold_pc  <= in_rs_pc;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic
// compared against a behavioural reference model.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_rob_clear;
  logic [5:0]  in_rs_op;
  logic [31:0] in_rs_value1;
  logic [31:0] in_rs_value2;
  logic [31:0] in_rs_imm;
  logic [3:0]  in_rs_rob_tag;
  logic [31:0] in_rs_pc;
  logic [3:0]  out_cdb_tag;
  logic [31:0] out_cdb_value;
  logic        out_cdb_jump_flag;
  logic [31:0] out_cdb_target;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_rob_clear      (in_rob_clear),
    .in_rs_op          (in_rs_op),
    .in_rs_value1      (in_rs_value1),
    .in_rs_value2      (in_rs_value2),
    .in_rs_imm         (in_rs_imm),
    .in_rs_rob_tag     (in_rs_rob_tag),
    .in_rs_pc          (in_rs_pc),
    .out_cdb_tag       (out_cdb_tag),
    .out_cdb_value     (out_cdb_value),
    .out_cdb_jump_flag (out_cdb_jump_flag),
    .out_cdb_target    (out_cdb_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [3:0]  tag;
    logic [31:0] pc;
  } ent_t;

  // Reference model state
  logic        m_hold_valid;
  ent_t        m_hold;
  logic [3:0]  exp_tag;
  logic [31:0] exp_value;
  logic [31:0] exp_target;
  logic        exp_jump;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic logic slt_s(input logic [31:0] a, input logic [31:0] b);
    // Flip the sign bits so a signed order becomes an unsigned one.
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] sra(input logic [31:0] a, input logic [4:0] sh);
    return a[31] ? ~((~a) >> sh) : (a >> sh);
  endfunction

  // Returns 1 for a recognised opcode and fills in the architectural results.
  function automatic logic ref_compute(input ent_t e, output logic [31:0] val,
                                       output logic [31:0] tgt, output logic jmp);
    logic known;
    known = 1'b1;
    val = 32'd0; tgt = 32'd0; jmp = 1'b0;
    case (e.op)
      OP_LUI:   val = e.imm;
      OP_AUIPC: val = e.pc + e.imm;
      OP_JAL:   begin val = e.pc + 4; tgt = e.pc + e.imm; jmp = 1'b1; end
      OP_JALR:  begin val = e.pc + 4; tgt = (e.v1 + e.imm) & 32'hFFFF_FFFE; jmp = 1'b1; end
      OP_BEQ:   begin tgt = e.pc + e.imm; jmp = (e.v1 == e.v2); end
      OP_BNE:   begin tgt = e.pc + e.imm; jmp = (e.v1 != e.v2); end
      OP_BLT:   begin tgt = e.pc + e.imm; jmp = slt_s(e.v1, e.v2); end
      OP_BGE:   begin tgt = e.pc + e.imm; jmp = !slt_s(e.v1, e.v2); end
      OP_BLTU:  begin tgt = e.pc + e.imm; jmp = (e.v1 < e.v2); end
      OP_BGEU:  begin tgt = e.pc + e.imm; jmp = !(e.v1 < e.v2); end
      OP_ADDI:  val = e.v1 + e.imm;
      OP_SLTI:  val = {31'd0, slt_s(e.v1, e.imm)};
      OP_SLTIU: val = {31'd0, e.v1 < e.imm};
      OP_XORI:  val = e.v1 ^ e.imm;
      OP_ORI:   val = e.v1 | e.imm;
      OP_ANDI:  val = e.v1 & e.imm;
      OP_SLLI:  val = e.v1 << e.imm[4:0];
      OP_SRLI:  val = e.v1 >> e.imm[4:0];
      OP_SRAI:  val = sra(e.v1, e.imm[4:0]);
      OP_ADD:   val = e.v1 + e.v2;
      OP_SUB:   val = e.v1 - e.v2;
      OP_SLL:   val = e.v1 << e.v2[4:0];
      OP_SLT:   val = {31'd0, slt_s(e.v1, e.v2)};
      OP_SLTU:  val = {31'd0, e.v1 < e.v2};
      OP_XOR:   val = e.v1 ^ e.v2;
      OP_SRL:   val = e.v1 >> e.v2[4:0];
      OP_SRA:   val = sra(e.v1, e.v2[4:0]);
      OP_OR:    val = e.v1 | e.v2;
      OP_AND:   val = e.v1 & e.v2;
      default:  known = 1'b0;
    endcase
    return known;
  endfunction

  task automatic model_reset();
    m_hold_valid = 1'b0;
    exp_tag = 4'd0; exp_value = 32'd0; exp_target = 32'd0; exp_jump = 1'b0;
  endtask

  task automatic model_broadcast(input ent_t e);
    logic k;
    k = ref_compute(e, exp_value, exp_target, exp_jump);
    exp_tag = e.tag;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    ent_t cur;
    logic [31:0] dv, dt;
    logic dj, valid_in;
    cur.op = in_rs_op; cur.v1 = in_rs_value1; cur.v2 = in_rs_value2;
    cur.imm = in_rs_imm; cur.tag = in_rs_rob_tag; cur.pc = in_rs_pc;
    valid_in = ref_compute(cur, dv, dt, dj) && (cur.tag != 4'd0);
    exp_tag = 4'd0;
    if (in_rob_clear) begin
      m_hold_valid = 1'b0;
    end else if (!rdy) begin
      if (valid_in) begin
        m_hold = cur;
        m_hold_valid = 1'b1;
      end
    end else if (m_hold_valid) begin
      model_broadcast(m_hold);
      if (valid_in) m_hold = cur;
      else m_hold_valid = 1'b0;
    end else if (valid_in) begin
      model_broadcast(cur);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check({name, "_tag"}, 32'(out_cdb_tag), 32'(exp_tag));
    if (exp_tag != 4'd0) begin
      check({name, "_value"},  out_cdb_value, exp_value);
      check({name, "_target"}, out_cdb_target, exp_target);
      check({name, "_jump"},   32'(out_cdb_jump_flag), 32'(exp_jump));
    end
    $display("cyc %s: rdy=%0b clr=%0b op=%0d tag_in=%0d -> cdb tag=%0d val=%08h tgt=%08h j=%0b",
             name, rdy, in_rob_clear, in_rs_op, in_rs_rob_tag, out_cdb_tag,
             out_cdb_value, out_cdb_target, out_cdb_jump_flag);
    @(negedge clk);
  endtask

  task automatic drive(input op_e op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [3:0] tag, input logic [31:0] pc);
    in_rs_op = op; in_rs_value1 = v1; in_rs_value2 = v2;
    in_rs_imm = imm; in_rs_rob_tag = tag; in_rs_pc = pc;
  endtask

  task automatic idle_in();
    drive(OP_NOP, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; in_rob_clear = 1'b0;
    idle_in();
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_tag",    32'(out_cdb_tag), 32'd0);
    check("reset_value",  out_cdb_value, 32'd0);
    check("reset_target", out_cdb_target, 32'd0);
    check("reset_jump",   32'(out_cdb_jump_flag), 32'd0);
    rst = 1'b0;

    // 1: ADD 5 + -7
    drive(OP_ADD, 32'd5, 32'hFFFF_FFF9, 32'd0, 4'd3, 32'd0);
    step("t1_add");
    check("t1_tag_const", 32'(out_cdb_tag), 32'd3);
    check("t1_val_const", out_cdb_value, 32'hFFFF_FFFE);
    idle_in();
    step("t1_idle");
    check("t1_idle_const", 32'(out_cdb_tag), 32'd0);

    // 2: BLTU taken, BLT not taken with the same operands
    drive(OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'h20, 4'd5, 32'h100);
    step("t2_bltu");
    check("t2_bltu_jump", 32'(out_cdb_jump_flag), 32'd1);
    check("t2_bltu_tgt", out_cdb_target, 32'h120);
    drive(OP_BLT, 32'd1, 32'hFFFF_FFFF, 32'h20, 4'd5, 32'h100);
    step("t2_blt");
    check("t2_blt_jump", 32'(out_cdb_jump_flag), 32'd0);

    // 3: JALR clears bit 0 of the target
    drive(OP_JALR, 32'h1001, 32'd0, 32'd4, 4'd6, 32'h40);
    step("t3_jalr");
    check("t3_val", out_cdb_value, 32'h44);
    check("t3_tgt", out_cdb_target, 32'h1004);
    check("t3_jump", 32'(out_cdb_jump_flag), 32'd1);
    idle_in();
    step("t3_idle");

    // 4: SUB parked across three frozen edges, broadcast once when running again
    rdy = 1'b0;
    drive(OP_SUB, 32'd100, 32'd1, 32'd0, 4'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("t4_frozen");
      check("t4_frozen_const", 32'(out_cdb_tag), 32'd0);
    end
    rdy = 1'b1;
    idle_in();
    step("t4_release");
    check("t4_release_const", 32'(out_cdb_tag), 32'd2);
    check("t4_release_val", out_cdb_value, 32'd99);
    step("t4_after");
    check("t4_after_const", 32'(out_cdb_tag), 32'd0);

    // 5: flush with a full hold buffer and a new SRAI
    rdy = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2, 32'd0, 4'd5, 32'd0);
    step("t5_park");
    rdy = 1'b1; in_rob_clear = 1'b1;
    drive(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 4'd7, 32'd0);
    step("t5_clear");
    check("t5_clear_const", 32'(out_cdb_tag), 32'd0);
    in_rob_clear = 1'b0;
    idle_in();
    step("t5_next");
    check("t5_next_const", 32'(out_cdb_tag), 32'd0);

    // 6: asynchronous reset between edges
    drive(OP_ORI, 32'hF0, 32'd0, 32'h0F, 4'd4, 32'd0);
    step("t6_bcast");
    check("t6_bcast_const", 32'(out_cdb_tag), 32'd4);
    idle_in();
    rst = 1'b1;
    #1;
    check("t6_async_tag", 32'(out_cdb_tag), 32'd0);
    check("t6_async_value", out_cdb_value, 32'd0);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rdy          = ($urandom_range(0, 3) != 0);
      in_rob_clear = ($urandom_range(0, 19) == 0);
      in_rs_op     = 6'($urandom_range(0, 40));
      in_rs_value1 = rand_word();
      in_rs_value2 = ($urandom_range(0, 4) == 0) ? in_rs_value1 : rand_word();
      in_rs_imm    = rand_word();
      in_rs_rob_tag = 4'($urandom_range(0, 15));
      in_rs_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
